// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: state / owner encoding and the
// round-robin pick used at every arbitration edge.
package dmem_arb_pkg;

  // State encoding doubles as the owner code seen on the debug display.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_G_CPU  = 2'b01,
    ST_G_HOST = 2'b10
  } arb_state_e;

  // Pick the next owner from the effective requests. On a tie the requester
  // that did not hold the most recent grant wins.
  function automatic arb_state_e rr_pick(input logic       eff_cpu,
                                         input logic       eff_host,
                                         input arb_state_e last_owner);
    arb_state_e pick;
    pick = ST_IDLE;
    if (eff_cpu && eff_host) begin
      pick = (last_owner == ST_G_CPU) ? ST_G_HOST : ST_G_CPU;
    end else if (eff_cpu) begin
      pick = ST_G_CPU;
    end else if (eff_host) begin
      pick = ST_G_HOST;
    end
    return pick;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the cpu control unit and the host
// load/debug port. Registered grant FSM with round-robin on contention,
// host lock, and a fixed one-cycle read return path per requester.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no owner this cycle, RAM port driven to zero
//   ST_G_CPU  | cpu owns the RAM port this cycle (access if cpu_req held)
//   ST_G_HOST | host owns the RAM port this cycle (access if host_req held)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              host_req_i,
  input  logic              host_wr_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              host_lock_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        owner_o
);

  arb_state_e state_q, state_d;
  arb_state_e last_q, last_d;
  logic       cpu_rvalid_q, host_rvalid_q;

  // Arbitration: the host lock masks the cpu only at the decision point, so a
  // cpu grant cycle already under way still completes.
  always_comb begin
    state_d = rr_pick(cpu_req_i & ~host_lock_i, host_req_i, last_q);
    last_d  = last_q;
    if (state_d != ST_IDLE) begin
      last_d = state_d;
    end
  end

  // State and last-owner registers; reset hands the first tie to the cpu.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= ST_G_HOST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // RAM port mux: the owner drives the port only while it still requests;
  // a dropped request cancels the access and leaves the port at zero.
  always_comb begin
    cpu_gnt_o   = 1'b0;
    host_gnt_o  = 1'b0;
    mem_addr_o  = '0;
    mem_wr_o    = 1'b0;
    mem_wdata_o = '0;
    case (state_q)
      ST_G_CPU: begin
        cpu_gnt_o = cpu_req_i;
        if (cpu_req_i) begin
          mem_addr_o  = cpu_addr_i;
          mem_wr_o    = cpu_wr_i;
          mem_wdata_o = cpu_wdata_i;
        end
      end
      ST_G_HOST: begin
        host_gnt_o = host_req_i;
        if (host_req_i) begin
          mem_addr_o  = host_addr_i;
          mem_wr_o    = host_wr_i;
          mem_wdata_o = host_wdata_i;
        end
      end
      default: ;
    endcase
  end

  // Read-return flags: the RAM answers one cycle after a granted read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q  <= cpu_gnt_o & ~cpu_wr_i;
      host_rvalid_q <= host_gnt_o & ~host_wr_i;
    end
  end

  assign cpu_rvalid_o  = cpu_rvalid_q;
  assign host_rvalid_o = host_rvalid_q;
  assign cpu_rdata_o   = cpu_rvalid_q  ? mem_rdata_i : '0;
  assign host_rdata_o  = host_rvalid_q ? mem_rdata_i : '0;

  // Stall is forced low during reset so every output reads zero there.
  assign cpu_stall_o = cpu_req_i & ~cpu_gnt_o & ~rst_i;
  assign owner_o     = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, host_req, host_wr, host_lock;
  logic [7:0]  cpu_addr, host_addr;
  logic [15:0] cpu_wdata, host_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid;
  logic [15:0] cpu_rdata, host_rdata;
  logic [7:0]  mem_addr;
  logic        mem_wr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .host_req_i(host_req), .host_wr_i(host_wr), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .host_lock_i(host_lock),
    .mem_addr_o(mem_addr), .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .owner_o(owner)
  );

  // Environment RAM: registered read, write on posedge, preload port.
  logic [15:0] tb_ram [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) tb_ram[pl_addr] <= pl_data;
    else if (mem_wr) tb_ram[mem_addr] <= mem_wdata;
    mem_rdata <= tb_ram[mem_addr];
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: owner 0 none / 1 cpu / 2 host, RAM image, read returns.
  int          m_own, m_last;
  bit          m_rv_c, m_rv_h;
  logic [15:0] m_rd_c, m_rd_h;
  logic [15:0] ref_mem [256];

  task automatic m_reset();
    m_own = 0; m_last = 2; m_rv_c = 0; m_rv_h = 0; m_rd_c = '0; m_rd_h = '0;
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic model_edge();
    bit gc, gh, ec, eh;
    if (rst) begin m_reset(); return; end
    gc = (m_own == 1) && cpu_req;
    gh = (m_own == 2) && host_req;
    m_rv_c = gc && !cpu_wr;  m_rd_c = ref_mem[cpu_addr];
    m_rv_h = gh && !host_wr; m_rd_h = ref_mem[host_addr];
    if (gc && cpu_wr)  ref_mem[cpu_addr]  = cpu_wdata;
    if (gh && host_wr) ref_mem[host_addr] = host_wdata;
    ec = cpu_req && !host_lock;
    eh = host_req;
    if (ec && eh)  m_own = (m_last == 1) ? 2 : 1;
    else if (ec)   m_own = 1;
    else if (eh)   m_own = 2;
    else           m_own = 0;
    if (m_own != 0) m_last = m_own;
  endtask

  task automatic check_outputs();
    bit gc, gh;
    logic [7:0]  ea;
    logic [15:0] ed;
    gc = (m_own == 1) && cpu_req && !rst;
    gh = (m_own == 2) && host_req && !rst;
    ea = gc ? cpu_addr  : (gh ? host_addr  : 8'h00);
    ed = gc ? cpu_wdata : (gh ? host_wdata : 16'h0000);
    chk("cpu_gnt",     cpu_gnt,     gc);
    chk("host_gnt",    host_gnt,    gh);
    chk("owner",       owner,       rst ? 0 : m_own);
    chk("cpu_stall",   cpu_stall,   cpu_req && !gc && !rst);
    chk("mem_wr",      mem_wr,      (gc && cpu_wr) || (gh && host_wr));
    chk("mem_addr",    mem_addr,    ea);
    chk("mem_wdata",   mem_wdata,   ed);
    chk("cpu_rvalid",  cpu_rvalid,  m_rv_c);
    chk("cpu_rdata",   cpu_rdata,   m_rv_c ? m_rd_c : 16'h0);
    chk("host_rvalid", host_rvalid, m_rv_h);
    chk("host_rdata",  host_rdata,  m_rv_h ? m_rd_h : 16'h0);
  endtask

  // Pending input values, applied just after the next rising edge.
  logic        n_creq, n_cwr, n_hreq, n_hwr, n_lock;
  logic [7:0]  n_caddr, n_haddr;
  logic [15:0] n_cwd, n_hwd;

  task automatic set_cpu(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
    n_creq = r; n_cwr = w; n_caddr = a; n_cwd = d;
  endtask
  task automatic set_host(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
    n_hreq = r; n_hwr = w; n_haddr = a; n_hwd = d;
  endtask
  task automatic set_idle();
    set_cpu(0, 0, 8'h00, 16'h0); set_host(0, 0, 8'h00, 16'h0); n_lock = 0;
  endtask
  task automatic apply();
    cpu_req = n_creq;  cpu_wr = n_cwr;  cpu_addr = n_caddr;  cpu_wdata = n_cwd;
    host_req = n_hreq; host_wr = n_hwr; host_addr = n_haddr; host_wdata = n_hwd;
    host_lock = n_lock;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    apply();
    @(negedge clk);
    check_outputs();
  endtask

  logic [15:0] saved10;

  initial begin
    rst = 1'b1;
    set_idle();
    apply();
    m_reset();

    // Preload RAM image while the arbiter is held in reset.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 8'(i);
      pl_data = (i == 5) ? 16'hBEEF : 16'($urandom);
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;

    // Reset state, with a pending cpu request that must not show as stall.
    cpu_req = 1'b1;
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_owner", owner, 0);
    chk("rst_gnt",   cpu_gnt, 0);
    chk("rst_rv",    cpu_rvalid, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 1: reset in the middle of a host write grant.
    saved10 = ref_mem[8'h10];
    set_host(1, 1, 8'h10, 16'hA5A5);
    step();
    step();
    chk("t1_wr_live", mem_wr, 1);
    #1;
    rst = 1'b1;
    m_reset();
    #1;
    chk("t1_memwr", mem_wr, 0);
    chk("t1_owner", owner, 0);
    chk("t1_hgnt",  host_gnt, 0);
    set_idle();
    apply();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t1_ram10", tb_ram[8'h10], saved10);

    // 3: contention straight after reset, cpu first then strict alternation.
    set_cpu(1, 0, 8'h01, 16'h0);
    set_host(1, 0, 8'h02, 16'h0);
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_owner", owner, (i % 2 == 0) ? 1 : 2);
    end
    set_idle();
    step(); step(); step();

    // 2: single cpu read of 8'h05.
    set_cpu(1, 0, 8'h05, 16'h0);
    step();
    step();
    chk("t2_gnt", cpu_gnt, 1);
    set_idle();
    step();
    chk("t2_rvalid", cpu_rvalid, 1);
    chk("t2_rdata",  cpu_rdata, 16'hBEEF);
    step();
    chk("t2_rv_once", cpu_rvalid, 0);

    // 4: host lock, host writes 0..3 = 1..4 while cpu waits.
    n_lock = 1;
    set_cpu(1, 0, 8'h40, 16'h0);
    set_host(1, 1, 8'h00, 16'h1);
    step();
    for (int k = 0; k < 4; k++) begin
      set_host(1, 1, 8'(k), 16'(k + 1));
      step();
      chk("t4_hgnt",  host_gnt, 1);
      chk("t4_stall", cpu_stall, 1);
      chk("t4_addr",  mem_addr, k);
    end
    n_lock = 0;
    set_host(0, 0, 8'h00, 16'h0);
    step();
    chk("t4_stall_end", cpu_stall, 1);
    step();
    chk("t4_cpu_next", cpu_gnt, 1);
    set_idle();
    step(); step();
    for (int k = 0; k < 4; k++) chk("t4_ram", tb_ram[k], k + 1);

    // 5: host abandons its request inside the grant cycle.
    set_host(1, 0, 8'h07, 16'h0);
    step();
    set_idle();
    step();
    chk("t5_hgnt",  host_gnt, 0);
    chk("t5_memwr", mem_wr, 0);
    chk("t5_owner", owner, 2);
    step();
    chk("t5_hrv",   host_rvalid, 0);

    // 6: back-to-back cpu write then read at 8'h20.
    set_cpu(1, 1, 8'h20, 16'h1234);
    step();
    step();
    chk("t6_wgnt", cpu_gnt, 1);
    set_cpu(1, 0, 8'h20, 16'h0);
    step();
    chk("t6_rgnt", cpu_gnt, 1);
    set_idle();
    step();
    chk("t6_rvalid", cpu_rvalid, 1);
    chk("t6_rdata",  cpu_rdata, 16'h1234);
    step();

    // Randomized traffic over a small address window to force read/write overlap.
    for (int i = 0; i < 400; i++) begin
      set_cpu($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
              8'($urandom_range(0, 15)), 16'($urandom));
      set_host($urandom_range(0, 99) < 50, $urandom_range(0, 1) == 1,
               8'($urandom_range(0, 15)), 16'($urandom));
      n_lock = ($urandom_range(0, 99) < 20);
      step();
    end
    set_idle();
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
